// File: rtl/dab_param_sequencer.sv
// dab_param_sequencer: validates host setpoints and sequences t1/t2/phi/fs into a DAB voltage generator
// Ports: clk/rst (async active-low) | cfg_valid/cfg_ready handshake with cfg_t1/cfg_t2/cfg_phi/cfg_fs
//        enable/estop run controls | period_start from the generator | t1/t2/phi/fs_DAB applied values
//        sync start pulse | running (ARM or RUN) | cfg_err sticky rejection flag
module dab_param_sequencer #(
  parameter int PHI_STEP = 4,
  parameter int FS_MIN   = 1000,
  parameter int FS_MAX   = 150000,
  parameter int FS_RST   = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic signed [8:0]  cfg_t1,
  input  logic signed [8:0]  cfg_t2,
  input  logic signed [8:0]  cfg_phi,
  input  logic signed [18:0] cfg_fs,
  input  logic               enable,
  input  logic               estop,
  input  logic               period_start,
  output logic signed [8:0]  t1,
  output logic signed [8:0]  t2,
  output logic signed [8:0]  phi,
  output logic signed [18:0] fs_DAB,
  output logic               sync,
  output logic               running,
  output logic               cfg_err
);
  typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;
  localparam logic signed [9:0] STEP = 10'(PHI_STEP);
  state_t state;
  logic signed [8:0] act_t1, act_t2, phi_target, ramp, stg_t1, stg_t2, stg_phi;
  logic signed [18:0] stg_fs;
  logic alive, loaded, pending, zeroed, cfg_ok, xfer, stopping, show;
  logic signed [9:0] tgt, diff, step, ramp_nxt;
  always_comb begin
    cfg_ok = !cfg_t1[8] && !cfg_t2[8] && cfg_phi != 9'h100 &&
             int'(cfg_fs) >= FS_MIN && int'(cfg_fs) <= FS_MAX;
    stopping = state == RUN && (!enable || estop);
    // alive holds ready low for the first edge after reset release
    cfg_ready = alive && (state == IDLE || (state == RUN && !pending && !stopping));
    xfer = cfg_valid && cfg_ready;
    // a pending target is applied before the ramp step on the same period_start
    tgt = pending ? stg_phi : phi_target;
    diff = tgt - ramp;
    step = diff > STEP ? STEP : diff < -STEP ? -STEP : diff;
    ramp_nxt = ramp + step;
    // a graceful stop keeps driving the last values until the next period boundary
    show = state == ARM || state == RUN || (state == STOP && !zeroed);
    t1 = show ? act_t1 : '0;
    t2 = show ? act_t2 : '0;
    phi = show ? ramp : '0;
    running = state == ARM || state == RUN;
    sync = state == ARM;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      act_t1 <= '0;
      act_t2 <= '0;
      fs_DAB <= 19'(FS_RST);
      phi_target <= '0;
      ramp <= '0;
      stg_t1 <= '0;
      stg_t2 <= '0;
      stg_phi <= '0;
      stg_fs <= '0;
      alive <= 1'b0;
      loaded <= 1'b0;
      pending <= 1'b0;
      zeroed <= 1'b1;
      cfg_err <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (xfer && !cfg_ok) cfg_err <= 1'b1;
      if (xfer && cfg_ok) begin
        cfg_err <= 1'b0;
        loaded <= 1'b1;
        if (state == IDLE) begin
          act_t1 <= cfg_t1;
          act_t2 <= cfg_t2;
          fs_DAB <= cfg_fs;
          phi_target <= cfg_phi;
        end else begin
          stg_t1 <= cfg_t1;
          stg_t2 <= cfg_t2;
          stg_fs <= cfg_fs;
          stg_phi <= cfg_phi;
          pending <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (estop) begin
            state <= STOP;
            zeroed <= 1'b1;
          end else if (enable && loaded) begin
            state <= ARM;
            ramp <= '0;
          end
        end
        ARM: begin
          state <= estop ? STOP : RUN;
          zeroed <= 1'b1;
        end
        RUN: begin
          if (stopping) begin
            state <= STOP;
            zeroed <= estop;
            pending <= 1'b0;
          end else if (period_start) begin
            if (pending) begin
              act_t1 <= stg_t1;
              act_t2 <= stg_t2;
              fs_DAB <= stg_fs;
              phi_target <= stg_phi;
              pending <= 1'b0;
            end
            ramp <= ramp_nxt[8:0];
          end
        end
        STOP: begin
          if (estop || period_start) zeroed <= 1'b1;
          if (zeroed && !enable && !estop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dab_param_sequencer.sv
// tb_dab_param_sequencer: directed scenarios checked against a rule-level model every cycle plus literal expectations
module tb_dab_param_sequencer;
  logic clk, rst, cfg_valid, cfg_ready, enable, estop, period_start, sync, running, cfg_err;
  logic signed [8:0] cfg_t1, cfg_t2, cfg_phi, t1, t2, phi;
  logic signed [18:0] cfg_fs, fs_DAB;
  int passed = 0, total = 0, sync_cnt = 0;
  dab_param_sequencer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_t1(cfg_t1), .cfg_t2(cfg_t2), .cfg_phi(cfg_phi), .cfg_fs(cfg_fs),
    .enable(enable), .estop(estop), .period_start(period_start),
    .t1(t1), .t2(t2), .phi(phi), .fs_DAB(fs_DAB),
    .sync(sync), .running(running), .cfg_err(cfg_err)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  int m_mode, m_t1, m_t2, m_fs, m_tgt, m_ramp, s_t1, s_t2, s_fs, s_phi;
  bit m_alive, m_loaded, m_pend, m_err, m_zero;
  function automatic bit m_ready();
    return m_alive && (m_mode == 0 || (m_mode == 2 && !m_pend && enable && !estop));
  endfunction
  function automatic int toward(int r, int t);
    int d = t - r;
    if (d > 4) d = 4;
    else if (d < -4) d = -4;
    return r + d;
  endfunction
  function automatic bit setpoint_ok(int a, int b, int p, int f);
    return a >= 0 && a <= 255 && b >= 0 && b <= 255 && p >= -255 && p <= 255 && f >= 1000 && f <= 150000;
  endfunction
  always @(posedge clk or negedge rst) begin : model
    bit x;
    int pm;
    if (!rst) begin
      m_mode = 0; m_t1 = 0; m_t2 = 0; m_fs = 100000; m_tgt = 0; m_ramp = 0;
      m_alive = 0; m_loaded = 0; m_pend = 0; m_err = 0; m_zero = 1;
    end else begin
      x = cfg_valid && m_ready();
      pm = m_mode;
      case (pm)
        0: if (estop) begin m_mode = 3; m_zero = 1; end
           else if (enable && m_loaded) begin m_mode = 1; m_ramp = 0; end
        1: begin m_mode = estop ? 3 : 2; m_zero = 1; end
        2: if (estop || !enable) begin m_mode = 3; m_zero = estop; m_pend = 0; end
           else if (period_start) begin
             if (m_pend) begin m_t1 = s_t1; m_t2 = s_t2; m_fs = s_fs; m_tgt = s_phi; m_pend = 0; end
             m_ramp = toward(m_ramp, m_tgt);
           end
        default: begin
          if (m_zero && !enable && !estop) m_mode = 0;
          if (estop || period_start) m_zero = 1;
        end
      endcase
      if (x) begin
        if (!setpoint_ok(int'(cfg_t1), int'(cfg_t2), int'(cfg_phi), int'(cfg_fs))) m_err = 1;
        else begin
          m_err = 0;
          m_loaded = 1;
          if (pm == 0) begin m_t1 = cfg_t1; m_t2 = cfg_t2; m_fs = cfg_fs; m_tgt = cfg_phi; end
          else begin s_t1 = cfg_t1; s_t2 = cfg_t2; s_fs = cfg_fs; s_phi = cfg_phi; m_pend = 1; end
        end
      end
      m_alive = 1;
    end
  end
  task automatic chk(string n, int a, int e);
    total++;
    if (a == e) passed++;
    else $display("FAIL %s: got %0d, want %0d at %0t", n, a, e, $time);
  endtask
  always @(posedge clk) begin : compare
    bit show;
    #1;
    show = m_mode == 1 || m_mode == 2 || (m_mode == 3 && !m_zero);
    chk("cyc_t1", t1, show ? m_t1 : 0);
    chk("cyc_t2", t2, show ? m_t2 : 0);
    chk("cyc_phi", phi, show ? m_ramp : 0);
    chk("cyc_fs", fs_DAB, m_fs);
    chk("cyc_sync", sync, m_mode == 1);
    chk("cyc_running", running, m_mode == 1 || m_mode == 2);
    chk("cyc_err", cfg_err, m_err);
    chk("cyc_ready", cfg_ready, m_ready());
    if (sync) sync_cnt++;
  end
  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(int a, int b, int p, int f);
    int n = 0;
    @(negedge clk);
    cfg_valid = 1; cfg_t1 = 9'(a); cfg_t2 = 9'(b); cfg_phi = 9'(p); cfg_fs = 19'(f);
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", n, 0);
    @(negedge clk);
    cfg_valid = 0;
  endtask
  task automatic pulse();
    @(negedge clk);
    period_start = 1;
    @(negedge clk);
    period_start = 0;
    @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end
  initial begin
    int exp_ramp[8];
    exp_ramp = '{16, 12, 8, 4, 0, -4, -6, -6};
    rst = 1; cfg_valid = 0; cfg_t1 = 0; cfg_t2 = 0; cfg_phi = 0; cfg_fs = 0;
    enable = 0; estop = 0; period_start = 0;
    #2 rst = 0;
    #1;
    chk("rst_t1", t1, 0);
    chk("rst_phi", phi, 0);
    chk("rst_fs", fs_DAB, 100000);
    chk("rst_ready", cfg_ready, 0);
    chk("rst_running", running, 0);
    @(negedge clk);
    rst = 1;
    chk("ready_after_release", cfg_ready, 0);
    @(negedge clk);
    chk("ready_rise", cfg_ready, 1);
    send(100, 80, 20, 50000);
    chk("idle_load_fs", fs_DAB, 50000);
    chk("idle_t1_zero", t1, 0);
    enable = 1;
    wait_cyc(3);
    chk("s1_sync_cnt", sync_cnt, 1);
    chk("s1_t1", t1, 100);
    chk("s1_t2", t2, 80);
    chk("s1_phi0", phi, 0);
    for (int k = 1; k <= 6; k++) begin
      pulse();
      chk("s1_ramp", phi, k * 4 > 20 ? 20 : k * 4);
    end
    send(100, 80, -6, 50000);
    chk("s2_ready_low", cfg_ready, 0);
    chk("s2_phi_hold", phi, 20);
    for (int k = 0; k < 8; k++) begin
      pulse();
      chk("s2_ramp", phi, exp_ramp[k]);
      if (k == 0) chk("s2_ready_back", cfg_ready, 1);
    end
    send(100, 80, -6, 200000);
    chk("s3_err_fs", cfg_err, 1);
    chk("s3_phi", phi, -6);
    send(-1, 80, -6, 50000);
    chk("s3_err_t1", cfg_err, 1);
    chk("s3_ready", cfg_ready, 1);
    send(100, 80, -6, 50000);
    chk("s3_err_clear", cfg_err, 0);
    pulse();
    send(50, 40, 10, 60000);
    @(negedge clk);
    estop = 1; period_start = 1;
    @(negedge clk);
    estop = 0; period_start = 0;
    chk("s4_t1", t1, 0);
    chk("s4_t2", t2, 0);
    chk("s4_phi", phi, 0);
    chk("s4_fs", fs_DAB, 50000);
    wait_cyc(3);
    chk("s4_stop_ready", cfg_ready, 0);
    chk("s4_stop_running", running, 0);
    chk("s4_sync_cnt", sync_cnt, 1);
    enable = 0;
    wait_cyc(2);
    chk("s4_idle_ready", cfg_ready, 1);
    enable = 1;
    wait_cyc(3);
    chk("s5_sync_cnt", sync_cnt, 2);
    chk("s5_t1_kept", t1, 100);
    chk("s5_phi0", phi, 0);
    pulse();
    chk("s5_ramp1", phi, -4);
    pulse();
    chk("s5_ramp2", phi, -6);
    enable = 0;
    wait_cyc(2);
    chk("s5_hold_t1", t1, 100);
    chk("s5_hold_phi", phi, -6);
    chk("s5_hold_running", running, 0);
    pulse();
    chk("s5_zero_t1", t1, 0);
    chk("s5_zero_phi", phi, 0);
    chk("s5_idle_ready", cfg_ready, 1);
    enable = 1;
    wait_cyc(3);
    chk("s5_resync", sync_cnt, 3);
    chk("s5_rephi", phi, 0);
    pulse();
    chk("s5_reramp", phi, -4);
    send(100, 80, 40, 50000);
    pulse();
    chk("s6_apply", phi, 0);
    pulse();
    chk("s6_ramp", phi, 4);
    @(negedge clk);
    #3 rst = 0;
    #1;
    chk("s6_async_t1", t1, 0);
    chk("s6_async_phi", phi, 0);
    chk("s6_async_fs", fs_DAB, 100000);
    chk("s6_async_running", running, 0);
    chk("s6_async_ready", cfg_ready, 0);
    @(negedge clk);
    rst = 1;
    wait_cyc(5);
    chk("s6_no_sync", sync_cnt, 3);
    chk("s6_running", running, 0);
    chk("s6_ready", cfg_ready, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
